window_serializer: RTL

//  Transmit side of the PIM serial-window stream: accepts one kernal*kernal-bit

---
 rtl/window_serializer.sv | 98 +++++++++
 1 files changed

// File: rtl/window_serializer.sv
// Parallel-in, serial-out window transmitter feeding the downstream serial accumulator.
// A holding register lets windows arrive back-to-back, so the stream has no idle bit between them.
module window_serializer #(
  parameter int kernal = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [kernal*kernal-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_bit,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       busy
);

  localparam int N  = kernal * kernal;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state, state_n;
  logic [N-1:0]  s, s_n;
  logic [N-1:0]  h, h_n;
  logic          h_full, h_full_n;
  logic [CW-1:0] idx, idx_n;
  logic          accept;

  // Ready depends only on registers and rst, never on in_valid.
  assign in_ready = !h_full && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT) || h_full;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    state_n  = state;
    s_n      = s;
    h_n      = h;
    h_full_n = h_full;
    idx_n    = idx;

    if (state == IDLE) begin
      if (accept) begin
        s_n     = in_data;
        idx_n   = '0;
        state_n = SHIFT;
      end
    end else if (idx == LAST_IDX) begin
      // End of window: the held window wins, then a same-edge bypass, otherwise go idle.
      idx_n = '0;
      if (h_full) begin
        s_n      = h;
        h_full_n = 1'b0;
      end else if (accept) begin
        s_n = in_data;
      end else begin
        state_n = IDLE;
      end
    end else begin
      idx_n = idx + CW'(1);
      if (accept) begin
        h_n      = in_data;
        h_full_n = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state, so each output cycle reflects the bit at idx.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: data registers are cleared too, so a window cut short by reset can never resurface.
      state     <= IDLE;
      s         <= '0;
      h         <= '0;
      h_full    <= 1'b0;
      idx       <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      h         <= h_n;
      h_full    <= h_full_n;
      idx       <= idx_n;
      out_valid <= (state_n == SHIFT);
      out_bit   <= (state_n == SHIFT) && s_n[idx_n];
      out_first <= (state_n == SHIFT) && (idx_n == '0);
      out_last  <= (state_n == SHIFT) && (idx_n == LAST_IDX);
    end
  end

endmodule
